// File: rtl/pio_osr_pkg.sv
// Shared PIO constants and helpers used by both the ISR and OSR datapaths.
package pio_osr_pkg;

  localparam int PIO_WORD_W = 32;
  localparam int PIO_CNT_W  = 7;

  typedef enum logic {
    SHIFT_LEFT  = 1'b0,
    SHIFT_RIGHT = 1'b1
  } shift_dir_e;

  // 5-bit architectural count fields encode 32 as 0.
  function automatic logic [PIO_CNT_W-1:0] decode_count5(input logic [4:0] v);
    return (v == 5'd0) ? 7'd32 : {2'b00, v};
  endfunction

endpackage

// File: rtl/pio_shift_extract.sv
// Combinational shift/extract datapath: splits src into the n bits shifted out
// (right-aligned) and the remaining word, for either shift direction.
module pio_shift_extract
  import pio_osr_pkg::*;
(
  input  logic [PIO_WORD_W-1:0] src,
  input  logic [PIO_CNT_W-1:0]  n,
  input  shift_dir_e            dir,
  output logic [PIO_WORD_W-1:0] out_data,
  output logic [PIO_WORD_W-1:0] shifted
);

  logic [PIO_CNT_W-1:0] n_inv;

  assign n_inv = 7'd32 - n;

  always_comb begin
    if (n >= 7'd32) begin
      out_data = src;
      shifted  = '0;
    end else if (dir == SHIFT_RIGHT) begin
      out_data = src & ~({PIO_WORD_W{1'b1}} << n);
      shifted  = src >> n;
    end else begin
      out_data = src >> n_inv;
      shifted  = src << n;
    end
  end

endmodule

// File: rtl/pio_osr.sv
// PIO output shift register: PULL/MOV loading, OUT shifting and shift counting.
// Define PIO_OSR_AUTOPULL_EN to implement autopull on OUT; otherwise auto_pull is ignored.
module pio_osr
  import pio_osr_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        penable,
  input  logic        stalled,
  input  logic [31:0] din,
  input  logic        set,
  input  logic        pull,
  input  logic        pull_block,
  input  logic        pull_ifempty,
  input  logic        do_shift,
  input  logic [4:0]  shift,
  input  logic        dir,
  input  logic        auto_pull,
  input  logic [4:0]  pull_thresh,
  input  logic [31:0] fifo_data,
  input  logic        fifo_valid,
  output logic        fifo_pop,
  output logic        stall_req,
  output logic [31:0] out_data,
  output logic [31:0] dout,
  output logic [5:0]  shift_count
);

  logic [PIO_WORD_W-1:0] osr_reg, osr_next;
  logic [PIO_CNT_W-1:0]  count_reg, count_next;
  logic [PIO_CNT_W-1:0]  n, th, base, sum;
  logic [PIO_WORD_W-1:0] src, ext_out, ext_shifted;
  logic                  empty, tick, ap_empty;

  assign n     = decode_count5(shift);
  assign th    = decode_count5(pull_thresh);
  assign empty = count_reg >= th;
  // Reset also masks the strobes so a held instruction cannot pop or stall during reset.
  assign tick  = penable && !stalled && !reset;

`ifdef PIO_OSR_AUTOPULL_EN
  assign ap_empty = auto_pull && empty;
`else
  logic autopull_unused;
  assign autopull_unused = auto_pull;
  assign ap_empty        = 1'b0;
`endif

  // An autopull OUT shifts the FIFO head directly, as if it had just been loaded.
  assign src  = ap_empty ? fifo_data : osr_reg;
  assign base = ap_empty ? '0 : count_reg;
  assign sum  = base + n;

  pio_shift_extract u_extract (
    .src      (src),
    .n        (n),
    .dir      (shift_dir_e'(dir)),
    .out_data (ext_out),
    .shifted  (ext_shifted)
  );

  assign out_data = (do_shift && !(ap_empty && !fifo_valid)) ? ext_out : '0;

  always_comb begin
    osr_next   = osr_reg;
    count_next = count_reg;
    fifo_pop   = 1'b0;
    stall_req  = 1'b0;
    if (tick) begin
      if (set) begin
        osr_next   = din;
        count_next = '0;
      end else if (pull) begin
        if (pull_ifempty && !empty) begin
          osr_next = osr_reg;
        end else if (fifo_valid) begin
          osr_next   = fifo_data;
          count_next = '0;
          fifo_pop   = 1'b1;
        end else if (pull_block) begin
          stall_req = 1'b1;
        end else begin
          osr_next   = din;
          count_next = '0;
        end
      end else if (do_shift) begin
        if (ap_empty && !fifo_valid) begin
          stall_req = 1'b1;
        end else begin
          fifo_pop   = ap_empty;
          osr_next   = ext_shifted;
          count_next = (sum > 7'd32) ? 7'd32 : sum;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      osr_reg   <= '0;
      count_reg <= 7'd32;
    end else begin
      osr_reg   <= osr_next;
      count_reg <= count_next;
    end
  end

  assign dout        = osr_reg;
  assign shift_count = count_reg[5:0];

endmodule

// File: tb/tb_pio_osr.sv
// Self-checking bench for pio_osr: directed literal checks plus randomized
// traffic compared every cycle against an arithmetic model of the OSR.
module tb_pio_osr;

`ifdef PIO_OSR_AUTOPULL_EN
  localparam bit AP_EN = 1'b1;
`else
  localparam bit AP_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset, penable, stalled, set, pull, pull_block, pull_ifempty;
  logic        do_shift, dir, auto_pull, fifo_valid;
  logic [31:0] din, fifo_data;
  logic [4:0]  shift, pull_thresh;
  logic        fifo_pop, stall_req;
  logic [31:0] out_data, dout;
  logic [5:0]  shift_count;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  pio_osr dut (
    .clk(clk), .reset(reset), .penable(penable), .stalled(stalled), .din(din),
    .set(set), .pull(pull), .pull_block(pull_block), .pull_ifempty(pull_ifempty),
    .do_shift(do_shift), .shift(shift), .dir(dir), .auto_pull(auto_pull),
    .pull_thresh(pull_thresh), .fifo_data(fifo_data), .fifo_valid(fifo_valid),
    .fifo_pop(fifo_pop), .stall_req(stall_req), .out_data(out_data),
    .dout(dout), .shift_count(shift_count)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end else begin
      $display("chk %s = %h", name, act);
    end
  endtask

  // Model: shifting is done as multiplication/division by powers of two.
  function automatic void mshift(input longint unsigned s, input int n, input bit right,
                                 output longint unsigned o, output longint unsigned rem);
    longint unsigned p;
    p = 64'd1 << n;
    if (right) begin
      o   = s % p;
      rem = s / p;
    end else begin
      o   = s / (64'd1 << (32 - n));
      rem = (s * p) % (64'd1 << 32);
    end
  endfunction

  longint unsigned m_osr, nx_osr, m_src, m_o, m_rem;
  int              m_cnt, nx_cnt, m_n, m_th;
  bit              m_valid = 1'b0;
  bit              m_tick, m_ap, e_pop, e_stall;
  logic [31:0]     e_out;

  always @(negedge clk) begin
    #2;
    m_n    = (shift == 0) ? 32 : int'(shift);
    m_th   = (pull_thresh == 0) ? 32 : int'(pull_thresh);
    m_tick = penable && !stalled && !reset;
    m_ap   = AP_EN && auto_pull && (m_cnt >= m_th);
    e_out = '0; e_pop = 0; e_stall = 0;
    nx_osr = m_osr; nx_cnt = m_cnt;
    if (do_shift && !(m_ap && !fifo_valid)) begin
      m_src = m_ap ? longint'(fifo_data) : m_osr;
      mshift(m_src, m_n, dir, m_o, m_rem);
      e_out = m_o[31:0];
    end
    if (m_tick) begin
      if (set) begin
        nx_osr = din; nx_cnt = 0;
      end else if (pull) begin
        if (pull_ifempty && m_cnt < m_th) begin
          nx_osr = m_osr;
        end else if (fifo_valid) begin
          nx_osr = fifo_data; nx_cnt = 0; e_pop = 1;
        end else if (pull_block) begin
          e_stall = 1;
        end else begin
          nx_osr = din; nx_cnt = 0;
        end
      end else if (do_shift) begin
        if (m_ap && !fifo_valid) begin
          e_stall = 1;
        end else begin
          e_pop  = m_ap;
          nx_osr = m_rem;
          nx_cnt = (m_ap ? 0 : m_cnt) + m_n;
          if (nx_cnt > 32) nx_cnt = 32;
        end
      end
    end
    if (reset) begin
      nx_osr = 0; nx_cnt = 32;
    end
    if (m_valid) begin
      n_checks += 5;
      if (dout !== m_osr[31:0]) begin
        n_errors++; $display("FAIL model_dout actual=%h required=%h", dout, m_osr[31:0]);
      end
      if (shift_count !== 6'(m_cnt)) begin
        n_errors++; $display("FAIL model_count actual=%0d required=%0d", shift_count, m_cnt);
      end
      if (fifo_pop !== e_pop) begin
        n_errors++; $display("FAIL model_pop actual=%b required=%b", fifo_pop, e_pop);
      end
      if (stall_req !== e_stall) begin
        n_errors++; $display("FAIL model_stall actual=%b required=%b", stall_req, e_stall);
      end
      if (out_data !== e_out) begin
        n_errors++; $display("FAIL model_out actual=%h required=%h", out_data, e_out);
      end
    end
    m_osr   = nx_osr;
    m_cnt   = nx_cnt;
    m_valid = m_valid || reset;
  end

  task automatic idle();
    reset = 0; penable = 1; stalled = 0; set = 0; pull = 0; pull_block = 0;
    pull_ifempty = 0; do_shift = 0; shift = 0; dir = 0; auto_pull = 0;
    pull_thresh = 0; fifo_valid = 0; fifo_data = 0; din = 0;
  endtask

  // Drive one instruction cycle: wait for the falling edge, clear, then caller sets fields.
  task automatic next_cycle();
    @(negedge clk);
    idle();
  endtask

  initial begin
    idle();
    reset = 1;
    repeat (2) @(negedge clk);
    reset = 1;
    next_cycle();
    #3 chk("reset_dout", dout, 32'h0);
    chk("reset_count", 32'(shift_count), 32'd32);
    chk("reset_pop", 32'(fifo_pop), 32'd0);
    chk("reset_stall", 32'(stall_req), 32'd0);

    next_cycle(); pull = 1; fifo_valid = 1; fifo_data = 32'hDEADBEEF;
    #3 chk("pull_pop", 32'(fifo_pop), 32'd1);
    next_cycle(); dir = 1; do_shift = 1; shift = 5'd8;
    #3 chk("pull_dout", dout, 32'hDEADBEEF);
    chk("pull_count", 32'(shift_count), 32'd0);
    chk("pull_pop_once", 32'(fifo_pop), 32'd0);
    chk("r8_out", out_data, 32'h000000EF);
    next_cycle(); dir = 1; do_shift = 1; shift = 5'd0;
    #3 chk("r8_dout", dout, 32'h00DEADBE);
    chk("r8_count", 32'(shift_count), 32'd8);
    chk("r32_out", out_data, 32'h00DEADBE);
    next_cycle(); pull = 1; fifo_valid = 1; fifo_data = 32'hDEADBEEF;
    #3 chk("r32_dout", dout, 32'h0);
    chk("r32_count", 32'(shift_count), 32'd32);
    next_cycle(); dir = 0; do_shift = 1; shift = 5'd4;
    #3 chk("l4_out", out_data, 32'h0000000D);
    next_cycle();
    #3 chk("l4_dout", dout, 32'hEADBEEF0);
    chk("l4_count", 32'(shift_count), 32'd4);

    // Autopull scenario: reach count=8 first.
    next_cycle(); set = 1; din = 32'hAABBCCDD;
    next_cycle(); dir = 1; do_shift = 1; shift = 5'd8;
    #3 chk("pre_ap_out", out_data, 32'h000000DD);
    if (AP_EN) begin
      next_cycle(); dir = 1; do_shift = 1; shift = 5'd4; auto_pull = 1; pull_thresh = 5'd8;
      #3 chk("ap_stall", 32'(stall_req), 32'd1);
      chk("ap_stall_out", out_data, 32'h0);
      next_cycle(); dir = 1; do_shift = 1; shift = 5'd4; auto_pull = 1; pull_thresh = 5'd8;
      fifo_valid = 1; fifo_data = 32'h12345678;
      #3 chk("ap_hold_count", 32'(shift_count), 32'd8);
      chk("ap_pop", 32'(fifo_pop), 32'd1);
      chk("ap_out", out_data, 32'h00000008);
      next_cycle();
      #3 chk("ap_dout", dout, 32'h01234567);
      chk("ap_count", 32'(shift_count), 32'd4);
    end else begin
      next_cycle(); dir = 1; do_shift = 1; shift = 5'd4; auto_pull = 1; pull_thresh = 5'd8;
      fifo_valid = 1; fifo_data = 32'h12345678;
      #3 chk("noap_pop", 32'(fifo_pop), 32'd0);
      chk("noap_stall", 32'(stall_req), 32'd0);
      chk("noap_out", out_data, 32'h0000000C);
      next_cycle();
      #3 chk("noap_dout", dout, 32'h000AABBC);
      chk("noap_count", 32'(shift_count), 32'd12);
    end

    next_cycle(); pull = 1; din = 32'hCAFEF00D;
    #3 chk("nb_pop", 32'(fifo_pop), 32'd0);
    next_cycle();
    #3 chk("nb_dout", dout, 32'hCAFEF00D);
    chk("nb_count", 32'(shift_count), 32'd0);

    for (int i = 0; i < 3; i++) begin
      next_cycle(); pull = 1; pull_block = 1;
      #3 chk("blk_stall", 32'(stall_req), 32'd1);
    end
    next_cycle(); pull = 1; pull_block = 1; fifo_valid = 1; fifo_data = 32'h0BADF00D;
    #3 chk("blk_release_stall", 32'(stall_req), 32'd0);
    chk("blk_release_pop", 32'(fifo_pop), 32'd1);

    next_cycle(); dir = 1; do_shift = 1; shift = 5'd3;
    next_cycle(); pull = 1; pull_ifempty = 1; pull_thresh = 5'd8; fifo_valid = 1;
    fifo_data = 32'h11111111;
    #3 chk("ife_pop", 32'(fifo_pop), 32'd0);
    next_cycle(); stalled = 1; pull = 1; fifo_valid = 1; fifo_data = 32'h22222222;
    #3 chk("ife_count", 32'(shift_count), 32'd3);
    chk("stalled_pop", 32'(fifo_pop), 32'd0);
    next_cycle(); penable = 0; do_shift = 1; shift = 5'd4; dir = 1;
    #3 chk("stalled_count", 32'(shift_count), 32'd3);
    next_cycle();
    #3 chk("penable_count", 32'(shift_count), 32'd3);
    chk("penable_dout", dout, 32'h0BADF00D >> 3);

    // Reset arriving while a blocking PULL is stalled.
    next_cycle(); set = 1; din = 32'h55AA55AA;
    next_cycle(); pull = 1; pull_block = 1;
    #3 chk("rst_blk_stall", 32'(stall_req), 32'd1);
    next_cycle(); pull = 1; pull_block = 1; reset = 1;
    next_cycle(); pull = 1; pull_block = 1; reset = 1;
    #3 chk("rst_blk_count", 32'(shift_count), 32'd32);
    chk("rst_blk_stall_drop", 32'(stall_req), 32'd0);
    chk("rst_blk_dout", dout, 32'h0);

    // Randomized traffic, checked by the model process every cycle.
    for (int i = 0; i < 800; i++) begin
      int r;
      next_cycle();
      r = int'($urandom_range(0, 99));
      if (r < 6) set = 1;
      else if (r < 30) pull = 1;
      else if (r < 85) do_shift = 1;
      pull_block   = 1'($urandom_range(0, 1));
      pull_ifempty = ($urandom_range(0, 3) == 0);
      shift        = 5'($urandom);
      dir          = 1'($urandom_range(0, 1));
      auto_pull    = 1'($urandom_range(0, 1));
      pull_thresh  = 5'($urandom);
      fifo_valid   = ($urandom_range(0, 9) < 6);
      fifo_data    = $urandom;
      din          = $urandom;
      penable      = ($urandom_range(0, 9) != 0);
      stalled      = ($urandom_range(0, 9) == 0);
      reset        = ($urandom_range(0, 99) == 0);
    end
    next_cycle();
    next_cycle();
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/pio_osr.md
Name: pio_osr

Overview:
- Output shift register for one PIO state machine; the transmit-side counterpart of the ISR.
- Loads 32-bit words from the TX FIFO via explicit PULL or autopull.
- Shifts 1–32 bits per OUT instruction towards pins or scratch registers, and tracks the shift count.
- Drives the TX FIFO pop strobe and a stall request back to the state-machine sequencer.

Parameters:
- (none; widths are fixed by the PIO architecture)

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high reset
- penable  input  1  state machine clock-enable tick
- stalled  input  1  sequencer is stalled this cycle; blocks all state updates
- din  input  32  data for MOV OSR, and X value for PULL noblock on an empty FIFO
- set  input  1  MOV OSR,src: load din
- pull  input  1  PULL instruction
- pull_block  input  1  PULL blocks when the FIFO is empty
- pull_ifempty  input  1  PULL only acts when count >= threshold
- do_shift  input  1  OUT instruction
- shift  input  5  OUT bit count; 0 means 32
- dir  input  1  1 = shift right (LSBs first), 0 = shift left (MSBs first)
- auto_pull  input  1  autopull enable (SHIFTCTRL)
- pull_thresh  input  5  autopull/ifempty threshold; 0 means 32
- fifo_data  input  32  TX FIFO head word
- fifo_valid  input  1  TX FIFO not empty
- fifo_pop  output  1  combinational pop strobe; one pulse per consumed word
- stall_req  output  1  combinational; current instruction cannot complete
- out_data  output  32  bits shifted out by the current OUT, right-aligned, zero-extended
- dout  output  32  current OSR contents (MOV src=OSR)
- shift_count  output  6  current shift count, 0..32

Behaviour:
- State: shift_reg[31:0], count[6:0] saturating at 32.
- Reset: shift_reg=0, count=32 (empty). Outputs at reset: dout=0, shift_count=32, fifo_pop=0, stall_req=0.
- Derived values: n = (shift==0)?32:shift; th = (pull_thresh==0)?32:pull_thresh; empty = count>=th.
- State changes only when penable && !stalled. Priority: set > pull > do_shift. fifo_pop and stall_req are forced to 0 when !penable or stalled.
- set: shift_reg<=din; count<=0.
- pull:
  - If pull_ifempty and !empty: no-op, no pop.
  - Else if fifo_valid: shift_reg<=fifo_data; count<=0; fifo_pop=1.
  - Else if pull_block: stall_req=1, no state change.
  - Else: shift_reg<=din (X); count<=0.
- do_shift, autopull path (auto_pull and empty):
  - fifo_valid=0: stall_req=1, no state change, out_data=0.
  - fifo_valid=1: fifo_pop=1; the shift operates on src=fifo_data with base count 0, in the same cycle.
- do_shift, otherwise: src=shift_reg, base count=count.
- Shift result:
  - Right: out_data = src & ~(~0<<n); shift_reg<=src>>n, zero-filled from the MSB.
  - Left: out_data = src>>(32-n); shift_reg<=src<<n, zero-filled from the LSB.
  - For n=32 the result is out_data=src, shift_reg<=0. All shift arithmetic uses 7-bit widths so that shifts by 32 are well defined.
  - count <= min(base+n, 32).
- out_data is combinational from current state and inputs, valid in the same cycle as do_shift. It is 0 when do_shift=0.
- No eager refill: the OSR never pops the FIFO except during a PULL or an autopull-triggered OUT.
- Reset asserted mid-stall: state returns to empty and stall_req drops the next cycle.
- Simultaneous set and do_shift: set wins, and out_data still reflects the shift of the current shift_reg. The sequencer never issues both; this is legal but not relied upon.

Optional Feature:
- Macro: PIO_OSR_AUTOPULL_EN.
- Defined: autopull is implemented exactly as described above.
- Undefined: auto_pull is ignored. OUT always shifts shift_reg, never pops or stalls, and a shift past 32 leaves zeros in the register.
- PULL, including ifempty, is identical in both builds.

Decomposition:
- Shared pio package holds:
  - PIO_WORD_W=32 and PIO_CNT_W=7.
  - A function decoding the 5-bit encoding where 0 means 32, used by both ISR and OSR.
  - A shift-direction enum (SHIFT_LEFT=0, SHIFT_RIGHT=1).
- One natural sub-module: pio_shift_extract, the combinational src/n/dir -> {out_data, shifted} datapath. It is reusable for ISR/OSR symmetry checks.

Test Plan:
- Reset, then check state: dout=0, shift_count=32. PULL with fifo_valid=1, fifo_data=32'hDEADBEEF -> fifo_pop=1 for one cycle; dout=32'hDEADBEEF; shift_count=0.
- Right shifts after loading 32'hDEADBEEF, dir=1:
  - OUT shift=8 -> out_data=32'hEF, dout=32'h00DEADBE, count=8.
  - OUT shift=0 (32) -> out_data=32'h00DEADBE, dout=0, count=32.
- Left shift after loading 32'hDEADBEEF, dir=0: OUT shift=4 -> out_data=32'hD, dout=32'hEADBEEF0, count=4.
- Autopull (auto_pull=1, pull_thresh=8, count=8):
  - fifo_valid=0 -> stall_req=1 with no state change.
  - Then fifo_valid=1 with fifo_data=32'h12345678, OUT shift=4 dir=1 -> fifo_pop=1, out_data=32'h8, dout=32'h01234567, count=4.
- PULL variants:
  - noblock on an empty FIFO with din=32'hCAFEF00D -> dout=32'hCAFEF00D, count=0, no pop.
  - block on an empty FIFO -> stall_req held high until fifo_valid rises.
  - ifempty with count=3, th=8 -> no-op.
- stalled=1 or penable=0 during OUT/PULL with fifo_valid=1 -> no pop and no state change. Reset asserted during a blocking stall -> count=32 and stall_req=0 the next cycle.
